// File: rtl/demux_dispatcher.sv
// rtl/demux_dispatcher.sv - word dispatcher for 4-channel demux, optional DISPATCH_FLIP_EN inversion/counter
module demux_dispatcher #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_data,
    input  logic [1:0] in_sel,
    input  logic       sel_mode,
    input  logic       in_valid,
`ifdef DISPATCH_FLIP_EN
    input  logic       flip,
    output logic [7:0] flip_count,
`endif
    output logic       in_ready,
    output logic [3:0] data,
    output logic [1:0] sel,
    output logic       out_valid,
    output logic       done,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // The counter counts down to 0 inclusive, so loading HOLD_CYCLES-1 yields HOLD_CYCLES DRIVE cycles.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t     state;
    logic [7:0] hold_cnt;
    logic [1:0] rr_ptr;
    logic [3:0] accept_data;

    assign in_ready = (state == IDLE);

`ifdef DISPATCH_FLIP_EN
    assign accept_data = flip ? ~in_data : in_data;
`else
    assign accept_data = in_data;
`endif

    // Dispatch FSM: accept in IDLE, hold the word for HOLD_CYCLES, then blank one GAP cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= 8'd0;
            rr_ptr    <= 2'd0;
            data      <= 4'd0;
            sel       <= 2'd0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
`ifdef DISPATCH_FLIP_EN
            flip_count <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (in_valid) begin
                        data      <= accept_data;
                        sel       <= sel_mode ? in_sel : rr_ptr;
                        if (!sel_mode) begin
                            rr_ptr <= rr_ptr + 2'd1;
                        end
                        hold_cnt  <= HOLD_LOAD;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= DRIVE;
`ifdef DISPATCH_FLIP_EN
                        if (flip && (flip_count != 8'hFF)) begin
                            flip_count <= flip_count + 8'd1;
                        end
`endif
                    end else begin
                        data      <= 4'd0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (hold_cnt == 8'd0) begin
                        data      <= 4'd0;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= GAP;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                GAP: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    data      <= 4'd0;
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_dispatcher.sv
// tb/tb_demux_dispatcher.sv - randomized self-checking bench for demux_dispatcher
module tb_demux_dispatcher;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_data;
    logic [1:0] in_sel;
    logic       sel_mode;
    logic       in_valid;

    logic       rdy4, ov4, done4, busy4;
    logic [3:0] data4;
    logic [1:0] sel4;
    logic       rdy1, ov1, done1, busy1;
    logic [3:0] data1;
    logic [1:0] sel1;

`ifdef DISPATCH_FLIP_EN
    logic       flip;
    logic [7:0] fc4, fc1;
    logic       w_flip [32];
`endif

    int         checks = 0;
    int         errors = 0;

    logic [1:0] rr_m;
    logic [7:0] fc_m;
    logic [3:0] w_data [32];
    logic [1:0] w_sel  [32];
    logic       w_mode [32];

    always #5 clk = ~clk;

    demux_dispatcher #(.HOLD_CYCLES(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .sel_mode  (sel_mode),
        .in_valid  (in_valid),
`ifdef DISPATCH_FLIP_EN
        .flip      (flip),
        .flip_count(fc4),
`endif
        .in_ready  (rdy4),
        .data      (data4),
        .sel       (sel4),
        .out_valid (ov4),
        .done      (done4),
        .busy      (busy4)
    );

    demux_dispatcher #(.HOLD_CYCLES(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .sel_mode  (sel_mode),
        .in_valid  (in_valid),
`ifdef DISPATCH_FLIP_EN
        .flip      (flip),
        .flip_count(fc1),
`endif
        .in_ready  (rdy1),
        .data      (data1),
        .sel       (sel1),
        .out_valid (ov1),
        .done      (done1),
        .busy      (busy1)
    );

    // observed vector: {in_ready, busy, done, out_valid, sel, data}
    task automatic get_obs(input int h, output logic [9:0] o);
        if (h == 1) o = {rdy1, busy1, done1, ov1, sel1, data1};
        else        o = {rdy4, busy4, done4, ov4, sel4, data4};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rr_m = 2'd0;
        fc_m = 8'd0;
    endtask

    // Words are accepted every h+2 edges; between accepts the inputs carry random junk.
    task automatic run_words(input int h, input int n, input string name);
        int         p;
        int         i;
        int         r;
        logic [1:0] sel_exp [32];
        logic [3:0] dat_exp [32];
        logic [9:0] o;
        logic [9:0] x;
        p = h + 2;
        for (int k = 0; k < n; k++) begin
            sel_exp[k] = w_mode[k] ? w_sel[k] : rr_m;
            if (!w_mode[k]) rr_m = rr_m + 2'd1;
            dat_exp[k] = w_data[k];
`ifdef DISPATCH_FLIP_EN
            if (w_flip[k]) begin
                dat_exp[k] = ~w_data[k];
                if (fc_m != 8'hFF) fc_m = fc_m + 8'd1;
            end
`endif
        end
        get_obs(h, o);
        checks++;
        if (o[9] !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_start act=%b exp=1", name, o[9]);
        end
        for (int e = 0; e < n * p; e++) begin
            i = e / p;
            r = e % p;
            if (r == 0) begin
                in_data  = w_data[i];
                in_sel   = w_sel[i];
                sel_mode = w_mode[i];
                in_valid = 1'b1;
`ifdef DISPATCH_FLIP_EN
                flip = w_flip[i];
`endif
            end else begin
                in_data  = 4'($urandom);
                in_sel   = 2'($urandom);
                sel_mode = 1'($urandom);
                in_valid = 1'($urandom);
`ifdef DISPATCH_FLIP_EN
                flip = 1'($urandom);
`endif
            end
            @(posedge clk);
            @(negedge clk);
            x[9]   = (r == h + 1);
            x[8]   = (r <= h);
            x[7]   = (r == h);
            x[6]   = (r < h);
            x[5:4] = sel_exp[i];
            x[3:0] = (r < h) ? dat_exp[i] : 4'd0;
            get_obs(h, o);
            checks++;
            if (o !== x) begin
                errors++;
                $display("FAIL %s edge=%0d word=%0d act={rdy,busy,done,ov,sel,data}=%b exp=%b", name, e, i, o, x);
            end
        end
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            x = {1'b1, 1'b0, 1'b0, 1'b0, sel_exp[n-1], 4'd0};
            get_obs(h, o);
            checks++;
            if (o !== x) begin
                errors++;
                $display("FAIL %s idle_tail act=%b exp=%b", name, o, x);
            end
        end
`ifdef DISPATCH_FLIP_EN
        checks++;
        if (((h == 1) ? fc1 : fc4) !== fc_m) begin
            errors++;
            $display("FAIL %s flip_count act=%0d exp=%0d", name, (h == 1) ? fc1 : fc4, fc_m);
        end
`endif
    endtask

    task automatic clear_words(input int n);
        for (int k = 0; k < n; k++) begin
            w_data[k] = 4'($urandom);
            w_sel[k]  = 2'($urandom);
            w_mode[k] = 1'b0;
`ifdef DISPATCH_FLIP_EN
            w_flip[k] = 1'b0;
`endif
        end
    endtask

    task automatic test_reset();
        logic [9:0] o;
        do_reset();
        get_obs(4, o);
        checks++;
        if (o !== 10'b1000_00_0000) begin
            errors++;
            $display("FAIL reset_state act=%b exp=%b", o, 10'b1000_00_0000);
        end
        in_data = 4'hA; sel_mode = 1'b0; in_sel = 2'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        get_obs(4, o);
        checks++;
        if (o !== 10'b0101_00_1010) begin
            errors++;
            $display("FAIL reset_pre_drive act=%b exp=%b", o, 10'b0101_00_1010);
        end
        #2 rst = 1'b1;
        #1;
        get_obs(4, o);
        checks++;
        if (o !== 10'b1000_00_0000) begin
            errors++;
            $display("FAIL reset_async act=%b exp=%b", o, 10'b1000_00_0000);
        end
        @(negedge clk);
        rst = 1'b0;
        rr_m = 2'd0;
        fc_m = 8'd0;
        clear_words(2);
        run_words(4, 2, "reset_rr_restart");
    endtask

    task automatic test_round_robin();
        do_reset();
        clear_words(5);
        for (int k = 0; k < 5; k++) w_data[k] = 4'(k + 1);
        run_words(4, 5, "round_robin");
    endtask

    task automatic test_explicit();
        do_reset();
        clear_words(3);
        w_data[0] = 4'h7; w_sel[0] = 2'd2; w_mode[0] = 1'b1;
        w_data[1] = 4'h9; w_sel[1] = 2'd2; w_mode[1] = 1'b1;
        w_data[2] = 4'h4; w_sel[2] = 2'd3; w_mode[2] = 1'b0;
        run_words(4, 3, "explicit_sel");
    endtask

    task automatic test_random_stability();
        clear_words(12);
        for (int k = 0; k < 12; k++) w_mode[k] = 1'($urandom);
        run_words(4, 12, "random_stability");
    endtask

    task automatic test_hold_one();
        do_reset();
        clear_words(8);
        for (int k = 0; k < 8; k++) w_mode[k] = 1'($urandom_range(0, 3) == 0);
        run_words(1, 8, "hold_one");
    endtask

`ifdef DISPATCH_FLIP_EN
    task automatic test_flip();
        do_reset();
        clear_words(2);
        w_data[0] = 4'b0011; w_flip[0] = 1'b1;
        w_data[1] = 4'b0011; w_flip[1] = 1'b0;
        run_words(4, 2, "flip");
    endtask
`endif

    initial begin
        rst = 1'b1;
        in_data = 4'd0;
        in_sel = 2'd0;
        sel_mode = 1'b0;
        in_valid = 1'b0;
`ifdef DISPATCH_FLIP_EN
        flip = 1'b0;
`endif
        rr_m = 2'd0;
        fc_m = 8'd0;
        test_reset();
        test_round_robin();
        test_explicit();
        test_random_stability();
        test_hold_one();
`ifdef DISPATCH_FLIP_EN
        test_flip();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_dispatcher.md
Name: demux_dispatcher

Overview:
- Sequential front-end that feeds the 4-channel demux stage.
- Accepts 4-bit words over a valid/ready handshake and latches each word.
- Drives the held word plus a 2-bit channel select for a fixed number of cycles, then blanks for one cycle.
- Channel comes from an internal round-robin pointer or from an explicit select sampled with the word.

Parameters:
- HOLD_CYCLES, 4, number of consecutive DRIVE cycles per word; legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  4  word to dispatch.
- in_sel  input  2  explicit channel; used only when sel_mode=1.
- sel_mode  input  1  0 = round-robin channel, 1 = in_sel.
- in_valid  input  1  in_data/in_sel/sel_mode are valid.
- in_ready  output  1  block can accept a word this cycle.
- data  output  4  word driven to demux data input.
- sel  output  2  channel driven to demux select.
- out_valid  output  1  data/sel hold a live word.
- done  output  1  one-cycle pulse after a word's last DRIVE cycle.
- busy  output  1  high in DRIVE and GAP.

Behaviour:
- Reset (async, any state, including mid-DRIVE): state=IDLE, data=0, sel=0, out_valid=0, done=0, busy=0, in_ready=1, rr_ptr=0, hold counter=0. Effect is immediate, not at the next edge.
- States: IDLE, DRIVE, GAP.
- in_ready = (state==IDLE), combinational from state only. It must not depend on in_valid.
- IDLE, accept when in_valid & in_ready at a rising edge:
  - data <= in_data.
  - sel <= sel_mode ? in_sel : rr_ptr.
  - If sel_mode=0: rr_ptr <= rr_ptr+1, 2-bit wrap 3->0. If sel_mode=1: rr_ptr unchanged.
  - counter <= HOLD_CYCLES-1; next state DRIVE.
- IDLE with in_valid=0: data=0, sel holds last value, out_valid=0.
- DRIVE:
  - out_valid=1, busy=1.
  - data/sel are stable and ignore all inputs, including changes to in_sel and sel_mode.
  - Counter decrements each cycle. When counter==0, next state is GAP.
  - Exactly HOLD_CYCLES DRIVE cycles per word; HOLD_CYCLES=1 gives one DRIVE cycle.
- GAP (exactly 1 cycle):
  - data=0, out_valid=0, done=1, busy=1, sel holds.
  - Next state IDLE.
  - Purpose: the demux outputs all read 0 between words.
- Latency: out_valid rises the cycle after the accept edge.
- Throughput: one word per HOLD_CYCLES+2 cycles (accept + DRIVE×HOLD_CYCLES + GAP).
- Counter width: 8 bits.
- All outputs are registered except in_ready.
- in_valid held high continuously: the next word is accepted on the first IDLE cycle after GAP. No word is lost or duplicated.

Optional Feature:
- Macro: DISPATCH_FLIP_EN
- Defined:
  - Extra input flip (1 bit) and extra output flip_count (8 bits), reset 0.
  - At accept, if flip=1 then data <= ~in_data and flip_count increments, saturating at 255.
  - Otherwise data <= in_data.
- Undefined: no flip port, no flip_count port, data <= in_data always.

Test Plan:
- Reset check: assert rst mid-DRIVE with data=4'hA -> same cycle data=0, out_valid=0, in_ready=1; after release, the next round-robin word goes to sel=0.
- Round-robin, HOLD_CYCLES=4, sel_mode=0, in_valid held, words 1,2,3,4,5 -> sel=0,1,2,3,0 in order; each word has out_valid high exactly 4 cycles; one done pulse and data=0 between words; period 6 cycles.
- Explicit select, sel_mode=1: in_sel=2 with word 4'h7, then in_sel=2 with word 4'h9 -> sel=2 for both; rr_ptr unchanged, so the next sel_mode=0 word goes to sel=0.
- Stability: during DRIVE toggle in_data, in_sel, sel_mode and in_valid -> data and sel constant; in_ready=0 throughout.
- HOLD_CYCLES=1, back-to-back valid -> pattern accept, DRIVE, GAP repeating every 3 cycles; out_valid one cycle wide.
- With DISPATCH_FLIP_EN defined: word 4'b0011 with flip=1 -> data=4'b1100, flip_count=1; word 4'b0011 with flip=0 -> data=4'b0011, flip_count=1.
